// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: direct-mapped write-back/write-allocate data cache with evict/refill FSM
module d_cache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        d_rdy,
    output logic [13:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy
);
    localparam int TAG_W = 14 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t r_state, w_next;
    logic [LINES-1:0] r_valid, r_dirty;
    logic [TAG_W-1:0] r_tag [LINES];
    logic [63:0] r_data [LINES];
    logic [13:0] r_maddr;
    logic [TAG_W-1:0] w_tag;
    logic [INDEX_BITS-1:0] w_idx, w_midx;
    logic [1:0] w_off;
    logic w_req, w_hit, w_miss;
    assign w_tag = d_addr[15:2+INDEX_BITS];
    assign w_idx = d_addr[1+INDEX_BITS:2];
    assign w_off = d_addr[1:0];
    assign w_midx = r_maddr[INDEX_BITS-1:0];
    assign w_req = re | we;
    assign w_hit = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == IDLE) & w_req & ~w_hit;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_miss ? ((r_valid[w_idx] & r_dirty[w_idx]) ? WRITEBACK : ALLOCATE) : IDLE;
            WRITEBACK: w_next = mem_rdy ? ALLOCATE : WRITEBACK;
            ALLOCATE:  w_next = mem_rdy ? IDLE : ALLOCATE;
            default:   w_next = IDLE;
        endcase
        mem_we = r_state == WRITEBACK;
        mem_re = r_state == ALLOCATE;
        // the victim tag is still in the array during writeback, so no copy is kept
        mem_addr = mem_we ? {r_tag[w_midx], w_midx} : r_maddr;
        mem_wdata = r_data[w_midx];
        d_rdy = ~rst & (r_state == IDLE) & (~w_req | w_hit);
        rd_data = (d_rdy & re & ~we) ? r_data[w_idx][{w_off, 4'b0} +: 16] : 16'h0000;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss)
                r_maddr <= d_addr[15:2];
            if ((r_state == IDLE) && we && w_hit) begin
                r_data[w_idx][{w_off, 4'b0} +: 16] <= wrt_data;
                r_dirty[w_idx] <= 1'b1;
            end
            if ((r_state == ALLOCATE) && mem_rdy) begin
                r_data[w_midx] <= mem_rdata;
                r_tag[w_midx] <= r_maddr[13:INDEX_BITS];
                r_valid[w_midx] <= 1'b1;
                r_dirty[w_midx] <= 1'b0;
            end
        end
    end
endmodule
